// File: rtl/pio_write_arbiter_if.sv
// Requester-side handshake and Avalon-MM PIO write bus shared by the arbiter.
// The slave modport is the arbiter's view; master is the requester/bus-model view.
interface pio_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 10
);
  logic [N_REQ-1:0]        req;
  logic [2*N_REQ-1:0]      req_addr;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [1:0]              address;
  logic                    chipselect;
  logic                    write_n;
  logic [31:0]             writedata;

  modport slave (
    input  req, req_addr, req_data,
    output ack, address, chipselect, write_n, writedata
  );

  modport master (
    output req, req_addr, req_data,
    input  ack, address, chipselect, write_n, writedata
  );
endinterface

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter serialising N requesters onto one Avalon-MM PIO write port.
// Each grant is a fixed IDLE -> WRITE -> ACK sequence; all outputs are registered.
module pio_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  pio_write_arbiter_if.slave       bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] last_grant
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     win, cand;
  logic              found;
  logic [1:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [N_REQ-1:0]  ack_d;
  logic [1:0]        address_d;
  logic [31:0]       writedata_d;
  logic              chipselect_d, write_n_d;
  logic [GW-1:0]     last_grant_d;

  function automatic logic [31:0] zext(input logic [DATA_W-1:0] d);
    return 32'(d);
  endfunction

  // Winner search starts at the pointer and walks upward with wrap.
  always_comb begin
    win      = ptr_q;
    cand     = '0;
    found    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win == GW'(i)) begin
        sel_addr = bus.req_addr[2*i +: 2];
        sel_data = bus.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    ack_d        = '0;
    address_d    = bus.address;
    writedata_d  = bus.writedata;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    last_grant_d = last_grant;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d      = WRITE;
          grant_d      = win;
          address_d    = sel_addr;
          writedata_d  = zext(sel_data);
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
        end
      end
      WRITE: begin
        state_d        = ACK;
        ack_d[grant_q] = 1'b1;
      end
      ACK: begin
        state_d      = IDLE;
        ptr_d        = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; reset abandons any write in flight without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      grant_q        <= '0;
      bus.ack        <= '0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      busy           <= 1'b0;
      last_grant     <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_q        <= grant_d;
      bus.ack        <= ack_d;
      bus.address    <= address_d;
      bus.writedata  <= writedata_d;
      bus.chipselect <= chipselect_d;
      bus.write_n    <= write_n_d;
      busy           <= (state_d != IDLE);
      last_grant     <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: drivers push expected writes computed from the
// round-robin rules, an independent monitor pops them as strobes and acks appear.
module tb_pio_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 10;
  localparam int GW = $clog2(N);
  localparam int AW = 2 * N;
  localparam int TW = DW * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic [GW-1:0] last_grant;

  always #5 clk = ~clk;

  pio_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  pio_write_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .last_grant (last_grant)
  );

  typedef struct {
    int          g;
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   strobe_cyc[$];
  int   checks    = 0;
  int   passes    = 0;
  int   cyc       = 0;
  int   model_ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference rule: first pending requester at or above the pointer, wrapping.
  function automatic int next_grant(input logic [N-1:0] s, input int p);
    for (int k = 0; k < N; k++)
      if (s[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Monitor: sampled 1 time unit after each rising edge.
  bit            ack_due = 1'b0;
  bit            lg_due  = 1'b0;
  int            ack_g   = 0;
  logic          rst_s;
  wr_t           mon_e;
  logic [N-1:0]  oh;

  initial begin
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) begin
        ack_due = 1'b0;
        lg_due  = 1'b0;
        chk("rst_chipselect", 32'(bus.chipselect), 32'd0);
        chk("rst_write_n",    32'(bus.write_n),    32'd1);
        chk("rst_address",    32'(bus.address),    32'd0);
        chk("rst_writedata",  bus.writedata,       32'd0);
        chk("rst_ack",        32'(bus.ack),        32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        chk("rst_last_grant", 32'(last_grant),     32'd0);
      end else begin
        if (lg_due) begin
          chk("last_grant", 32'(last_grant), 32'(ack_g));
          chk("busy_after_ack", 32'(busy), 32'd0);
          lg_due = 1'b0;
        end
        if (bus.chipselect && !bus.write_n) begin
          strobe_cyc.push_back(cyc);
          chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
          chk("ack_in_write", 32'(bus.ack), 32'd0);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("address",    32'(bus.address), 32'(mon_e.addr));
            chk("writedata",  bus.writedata,    mon_e.data);
            chk("busy_write", 32'(busy),        32'd1);
            ack_g   = mon_e.g;
            ack_due = 1'b1;
          end
        end else if (ack_due) begin
          oh        = '0;
          oh[ack_g] = 1'b1;
          chk("ack", 32'(bus.ack), 32'(oh));
          chk("strobe_off_in_ack", 32'({bus.chipselect, bus.write_n}), 32'b01);
          chk("busy_ack", 32'(busy), 32'd1);
          ack_due = 1'b0;
          lg_due  = 1'b1;
        end else begin
          chk("no_ack", 32'(bus.ack), 32'd0);
        end
      end
    end
  end

  task automatic run_batch(input logic [N-1:0] set, input logic [N-1:0] hold, input int n_grants,
                           input logic [AW-1:0] addrs, input logic [TW-1:0] datas,
                           input bit early_drop, output int c0);
    logic [N-1:0] pending;
    int           p, g, acks;
    wr_t          e;
    pending = set;
    p       = model_ptr;
    for (int n = 0; n < n_grants; n++) begin
      g      = next_grant(pending, p);
      e.g    = g;
      e.addr = addrs[2*g +: 2];
      e.data = 32'(datas[DW*g +: DW]);
      exp_q.push_back(e);
      p = (g + 1) % N;
      if (!hold[g]) pending[g] = 1'b0;
    end
    model_ptr = p;
    @(negedge clk);
    strobe_cyc.delete();
    bus.req_addr = addrs;
    bus.req_data = datas;
    bus.req      = set;
    c0           = cyc;
    acks         = 0;
    for (int t = 0; t < 40 * N && acks < n_grants; t++) begin
      @(negedge clk);
      if (early_drop && bus.chipselect && !bus.write_n) begin
        bus.req      = '0;
        bus.req_data = '0;
      end
      if (|bus.ack) begin
        acks++;
        for (int i = 0; i < N; i++)
          if (bus.ack[i] && !hold[i]) bus.req[i] = 1'b0;
        if (acks == n_grants) bus.req = '0;
      end
    end
    bus.req = '0;
    chk("batch_acks", 32'(acks), 32'(n_grants));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  int           c0;
  bit           found;
  wr_t          re;
  logic [N-1:0] rset, rhold;
  int           rn;

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single request from requester 1.
    run_batch(3'b010, '0, 1, {2'd0, 2'd0, 2'd0}, {10'h0, 10'h155, 10'h0}, 1'b0, c0);

    // Simultaneous requests from a fresh pointer: writes at t+1, t+4, t+7.
    do_reset();
    run_batch(3'b111, '0, 3, {2'd3, 2'd2, 2'd1}, {10'd3, 10'd2, 10'd1}, 1'b0, c0);
    chk("strobe_count", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      chk("strobe_t1", 32'(strobe_cyc[0]), 32'(c0 + 1));
      chk("strobe_t4", 32'(strobe_cyc[1]), 32'(c0 + 4));
      chk("strobe_t7", 32'(strobe_cyc[2]), 32'(c0 + 7));
    end

    // Fairness between two continuously held requesters.
    run_batch(3'b101, 3'b101, 6, {2'd1, 2'd0, 2'd2}, {10'h02C, 10'h0, 10'h01A}, 1'b0, c0);

    // Data changed and req dropped while the write is in flight.
    run_batch(3'b001, '0, 1, {2'd0, 2'd0, 2'd1}, {10'h0, 10'h0, 10'h3FF}, 1'b1, c0);

    // Reset during WRITE abandons the write; pointer returns to 0.
    @(negedge clk);
    re.g = 0; re.addr = 2'd2; re.data = 32'h0AB;
    exp_q.push_back(re);
    bus.req_addr = {2'd0, 2'd0, 2'd2};
    bus.req_data = {10'h0, 10'h0, 10'h0AB};
    bus.req      = 3'b001;
    found        = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.chipselect && !bus.write_n) found = 1'b1;
    end
    chk("rst_test_strobe", 32'(found), 32'd1);
    reset   = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    model_ptr = 0;
    run_batch(3'b110, '0, 2, {2'd2, 2'd1, 2'd0}, {10'h022, 10'h011, 10'h0}, 1'b0, c0);

    // Zero extension of the requester data.
    run_batch(3'b100, '0, 1, {2'd3, 2'd0, 2'd0}, {10'h2AA, 10'h0, 10'h0}, 1'b0, c0);

    // Randomised batches, some with requesters holding req across acks.
    for (int b = 0; b < 40; b++) begin
      rset  = N'($urandom_range(1, (1 << N) - 1));
      rhold = ($urandom_range(0, 3) == 0) ? (N'($urandom) & rset) : '0;
      rn    = $countones(rset);
      if (rhold != '0) rn = rn + $urandom_range(0, 3);
      run_batch(rset, rhold, rn, AW'($urandom), TW'($urandom), 1'b0, c0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
